// File: rtl/cic_pkg.sv
// Shared CIC definitions: rate decode, bit-growth constant and the legal interpolation factors.
package cic_pkg;

    localparam int unsigned GROWTH_PER_STAGE = 5;
    localparam int unsigned R_W              = 5;
    localparam int unsigned LOG2R_W          = 3;
    localparam int unsigned N_LEGAL_R        = 5;

    // Element [k] holds the legal factor 2**k.
    localparam logic [N_LEGAL_R-1:0][R_W-1:0] LEGAL_R = {5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

    typedef struct packed {
        logic [R_W-1:0]     r_eff;
        logic [LOG2R_W-1:0] log2r;
    } r_dec_t;

    // Any factor outside the legal list decodes as R=1.
    function automatic r_dec_t decode_r(input logic [R_W-1:0] r);
        r_dec_t d;
        d.r_eff = R_W'(1);
        d.log2r = '0;
        case (r)
            LEGAL_R[0]: begin d.r_eff = LEGAL_R[0]; d.log2r = LOG2R_W'(0); end
            LEGAL_R[1]: begin d.r_eff = LEGAL_R[1]; d.log2r = LOG2R_W'(1); end
            LEGAL_R[2]: begin d.r_eff = LEGAL_R[2]; d.log2r = LOG2R_W'(2); end
            LEGAL_R[3]: begin d.r_eff = LEGAL_R[3]; d.log2r = LOG2R_W'(3); end
            LEGAL_R[4]: begin d.r_eff = LEGAL_R[4]; d.log2r = LOG2R_W'(4); end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cic_integ.sv
// CIC integrator stage: modulo-2^W accumulator advanced only when enabled.
module cic_integ
    import cic_pkg::*;
#(
    parameter int unsigned W = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic signed [W-1:0] i_din,
    output logic signed [W-1:0] o_acc
);

    logic signed [W-1:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_din;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate combs, zero-stuffing upsampler, 6 MHz integrators,
// rounded and saturated output, all on the 18 MHz clock.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned Q          = 1,
    parameter int unsigned N          = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [4:0]                   R,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic                         in_req,
    output logic signed [DATA_WIDTH-1:0] x_out,
    output logic                         out_valid
);

    localparam int unsigned ACC_W  = DATA_WIDTH + GROWTH_PER_STAGE * Q;
    localparam int unsigned LOG2N  = $clog2(N);
    localparam int unsigned SH_W   = 5;
    localparam int unsigned TICK_W = 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [TICK_W-1:0]             r_tick_cnt;
    logic [R_W-1:0]                r_phase;
    logic                          r_in_req;
    logic                          r_out_valid;
    logic signed [DATA_WIDTH-1:0]  r_x_out;
    logic signed [ACC_W-1:0]       r_x;

    logic                          w_tick;
    logic                          w_inject;
    r_dec_t                        w_dec;
    logic [SH_W-1:0]               w_sh;
    logic signed [ACC_W-1:0]       w_stage [Q+1];
    logic signed [ACC_W-1:0]       w_up;
    logic signed [ACC_W-1:0]       w_int [Q];
    logic signed [ACC_W-1:0]       w_round;
    logic signed [ACC_W-1:0]       w_sum;
    logic signed [ACC_W-1:0]       w_v;
    logic signed [DATA_WIDTH-1:0]  w_sat;

    assign w_dec    = decode_r(R);
    assign w_tick   = (r_tick_cnt == TICK_W'(2));
    assign w_inject = w_tick && (r_phase == '0);

    // Divide-by-3 tick and phase counter; a shrunken R wraps the phase on the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_phase    <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            if (w_tick) begin
                if (r_phase >= (w_dec.r_eff - R_W'(1))) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + R_W'(1);
                end
            end
        end
    end

    // x_in is captured during the cycle in_req is visible, after the combs were sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
        end else if (r_in_req) begin
            r_x <= ACC_W'(x_in);
        end
    end

    assign w_stage[0] = r_x;

    for (genvar gi = 0; gi < Q; gi++) begin : g_comb
        for (genvar gk = 0; gk < N; gk++) begin : g_tap
            logic signed [ACC_W-1:0] r_q;
            if (gk == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (r_in_req) begin
                        r_q <= w_stage[gi];
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (r_in_req) begin
                        r_q <= g_tap[gk-1].r_q;
                    end
                end
            end
        end
        assign w_stage[gi+1] = w_stage[gi] - g_tap[N-1].r_q;
    end

    assign w_up = w_inject ? w_stage[Q] : '0;

    for (genvar gi = 0; gi < Q; gi++) begin : g_integ
        logic signed [ACC_W-1:0] w_din;
        if (gi == 0) begin : g_first
            assign w_din = w_up;
        end else begin : g_chain
            assign w_din = w_int[gi-1];
        end
        cic_integ #(.W(ACC_W)) u_integ (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_tick),
            .i_din (w_din),
            .o_acc (w_int[gi])
        );
    end

    // Normalise by (R*N)^Q / R with round-half-up, then clip to the output range.
    assign w_sh    = SH_W'((Q - 1) * w_dec.log2r + Q * LOG2N);
    assign w_round = (w_sh == '0) ? '0 : (ACC_W'(1) <<< (w_sh - SH_W'(1)));
    assign w_sum   = w_int[Q-1] + w_round;
    assign w_v     = w_sum >>> w_sh;

    always_comb begin
        w_sat = DATA_WIDTH'(w_v);
        if (w_v > SAT_MAX) begin
            w_sat = DATA_WIDTH'(SAT_MAX);
        end else if (w_v < SAT_MIN) begin
            w_sat = DATA_WIDTH'(SAT_MIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_req    <= 1'b0;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
        end else begin
            r_in_req    <= w_inject;
            r_out_valid <= w_tick;
            if (w_tick) begin
                r_x_out <= w_sat;
            end
        end
    end

    assign in_req    = r_in_req;
    assign out_valid = r_out_valid;
    assign x_out     = r_x_out;

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator: three instances (Q=1,2,3) driven with directed vectors.
module tb_cic_interpolator;

    typedef struct {
        int cyc;
        int val;
        bit chk_val;
        bit req;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [4:0]          r_sel     [3];
    logic signed [15:0]  x_in_a    [3];
    logic signed [15:0]  x_out_a   [3];
    logic                in_req_a  [3];
    logic                out_valid_a [3];

    exp_t exp_q [3][$];
    int   smp_q [3][$];
    int   smp_def [3];
    int   cyc;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t mon_e;

    always #5 clk = ~clk;

    cic_interpolator #(.DATA_WIDTH(16), .Q(1), .N(1)) u_q1 (
        .clk(clk), .rst_n(rst_n), .R(r_sel[0]), .x_in(x_in_a[0]),
        .in_req(in_req_a[0]), .x_out(x_out_a[0]), .out_valid(out_valid_a[0]));
    cic_interpolator #(.DATA_WIDTH(16), .Q(2), .N(1)) u_q2 (
        .clk(clk), .rst_n(rst_n), .R(r_sel[1]), .x_in(x_in_a[1]),
        .in_req(in_req_a[1]), .x_out(x_out_a[1]), .out_valid(out_valid_a[1]));
    cic_interpolator #(.DATA_WIDTH(16), .Q(3), .N(1)) u_q3 (
        .clk(clk), .rst_n(rst_n), .R(r_sel[2]), .x_in(x_in_a[2]),
        .in_req(in_req_a[2]), .x_out(x_out_a[2]), .out_valid(out_valid_a[2]));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string nm, input int inst, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s u%0d @cyc %0d: got %0d, want %0d", nm, inst, cyc, got, want);
        end
    endtask

    task automatic check_quiet(input string nm);
        for (int i = 0; i < 3; i++) begin
            check({nm, " x_out"}, i, int'(x_out_a[i]), 0);
            check({nm, " out_valid"}, i, int'(out_valid_a[i]), 0);
            check({nm, " in_req"}, i, int'(in_req_a[i]), 0);
        end
    endtask

    task automatic push_exp(input int inst, input int t, input bit chk, input int val, input bit req);
        exp_t e;
        e.cyc = 3 * t;
        e.val = val;
        e.chk_val = chk;
        e.req = req;
        exp_q[inst].push_back(e);
    endtask

    task automatic flush_all();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            smp_q[i].delete();
        end
    endtask

    task automatic check_drained(input string nm);
        for (int i = 0; i < 3; i++) check({nm, " drain"}, i, exp_q[i].size(), 0);
    endtask

    // Source: present the next sample while in_req is high so it is captured on the following edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (in_req_a[i]) begin
                    if (smp_q[i].size() != 0) x_in_a[i] = 16'(smp_q[i].pop_front());
                    else                      x_in_a[i] = 16'(smp_def[i]);
                end
            end
        end
    end

    // Monitor: every out_valid consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid_a[i] && exp_q[i].size() != 0) begin
                    mon_e = exp_q[i].pop_front();
                    check("strobe_cycle", i, cyc, mon_e.cyc);
                    check("in_req", i, int'(in_req_a[i]), int'(mon_e.req));
                    if (mon_e.chk_val) check("x_out", i, int'(x_out_a[i]), mon_e.val);
                end
            end
        end
    end

    initial begin
        int v;
        for (int i = 0; i < 3; i++) begin
            x_in_a[i] = '0;
            r_sel[i]  = 5'd1;
            smp_def[i] = 0;
        end

        // Phase A: strobes, zero-order hold, Q=2 shape and rounding, Q=3 DC.
        rst_n = 1'b0;
        flush_all();
        r_sel[0] = 5'd4;  smp_q[0] = '{0, 1000};          smp_def[0] = 0;
        r_sel[1] = 5'd2;  smp_q[1] = '{0, 1000, 0, 0, 0, 3}; smp_def[1] = 0;
        r_sel[2] = 5'd16; smp_def[2] = -12345;
        for (int t = 1; t <= 24; t++)
            push_exp(0, t, 1'b1, (t >= 10 && t <= 13) ? 1000 : 0, ((t - 1) % 4) == 0);
        for (int t = 1; t <= 20; t++) begin
            case (t)
                7:       v = 500;
                8:       v = 1000;
                9:       v = 500;
                15:      v = 2;
                16:      v = 3;
                17:      v = 2;
                default: v = 0;
            endcase
            push_exp(1, t, 1'b1, v, ((t - 1) % 2) == 0);
        end
        for (int t = 1; t <= 110; t++)
            push_exp(2, t, t >= 80, -12345, ((t - 1) % 16) == 0);
        repeat (5) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        rst_n = 1'b1;
        repeat (3 * 112) @(negedge clk);
        check_drained("phaseA");

        // Phase B: illegal R, R switch 16->1 into saturation, Q=3 alternating full scale.
        rst_n = 1'b0;
        flush_all();
        @(negedge clk);
        check_quiet("reset_B");
        r_sel[0] = 5'd5;  smp_q[0] = '{0, 0, 1000}; smp_def[0] = 0;
        r_sel[1] = 5'd16; smp_def[1] = 10000;
        r_sel[2] = 5'd2;  smp_def[2] = 0;
        for (int k = 0; k < 30; k++) smp_q[2].push_back((k % 2 == 0) ? 32767 : -32767);
        for (int t = 1; t <= 10; t++)
            push_exp(0, t, 1'b1, (t == 5) ? 1000 : 0, 1'b1);
        for (int t = 1; t <= 100; t++)
            push_exp(1, t, t >= 60, (t <= 85) ? 10000 : 32767,
                     (t <= 85) ? (((t - 1) % 16) == 0) : (t >= 87));
        for (int t = 1; t <= 40; t++) begin
            if (t < 6)       v = 0;
            else if (t == 6) v = 8192;
            else if (t == 7) v = 24575;
            else begin
                case ((t - 8) % 4)
                    0, 3:    v = 16384;
                    default: v = -16383;
                endcase
            end
            push_exp(2, t, 1'b1, v, ((t - 1) % 2) == 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (255) @(negedge clk);
        r_sel[1] = 5'd1;
        repeat (46) @(negedge clk);
        check_drained("phaseB");

        // Asynchronous reset while the Q=2 output sits at full scale.
        #2 rst_n = 1'b0;
        #1 check_quiet("async_reset");
        flush_all();
        @(negedge clk);
        check_quiet("held_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
